vrf_read_rr_arbiter: RTL

- Shares one VRF read port among NUM_REQ lane-side requesters (e.g. LSU, MAC, cross-lane and mask units) with a round-robin arbiter.
- The winning request is held in a one-entry registered output stage feeding the VRF read pipeline.
- Request payload is the VRF read request record: vs, readSource, offset, instructionIndex.
- Upgrade of the single-input pass-through arbiter to N fair-shared inputs with timing isolation.

---
 rtl/vrf_read_rr_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/vrf_read_rr_arbiter.sv
// Round-robin arbiter sharing one VRF read port among NUM_REQ requesters.
// The winner is captured in a one-entry registered output stage.
module vrf_read_rr_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned VS_W     = 5,
    parameter int unsigned SRC_W    = 2,
    parameter int unsigned OFF_W    = 6,
    parameter int unsigned IDX_W    = 3,
    parameter int unsigned CHOSEN_W = $clog2(NUM_REQ)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          io_in_valid,
    output logic [NUM_REQ-1:0]          io_in_ready,
    input  logic [NUM_REQ*VS_W-1:0]     io_in_bits_vs,
    input  logic [NUM_REQ*SRC_W-1:0]    io_in_bits_readSource,
    input  logic [NUM_REQ*OFF_W-1:0]    io_in_bits_offset,
    input  logic [NUM_REQ*IDX_W-1:0]    io_in_bits_instructionIndex,
    input  logic                        io_out_ready,
    output logic                        io_out_valid,
    output logic [VS_W-1:0]             io_out_bits_vs,
    output logic [SRC_W-1:0]            io_out_bits_readSource,
    output logic [OFF_W-1:0]            io_out_bits_offset,
    output logic [IDX_W-1:0]            io_out_bits_instructionIndex,
    output logic [CHOSEN_W-1:0]         io_out_chosen
);

    logic                out_valid_q,  out_valid_d;
    logic [VS_W-1:0]     out_vs_q,     out_vs_d;
    logic [SRC_W-1:0]    out_src_q,    out_src_d;
    logic [OFF_W-1:0]    out_off_q,    out_off_d;
    logic [IDX_W-1:0]    out_idx_q,    out_idx_d;
    logic [CHOSEN_W-1:0] out_chosen_q, out_chosen_d;
    logic [CHOSEN_W-1:0] ptr_q,        ptr_d;

    logic [CHOSEN_W-1:0] winner;
    logic                any_valid;
    logic                load;
    logic                grant;

    assign io_out_valid                 = out_valid_q;
    assign io_out_bits_vs               = out_vs_q;
    assign io_out_bits_readSource       = out_src_q;
    assign io_out_bits_offset           = out_off_q;
    assign io_out_bits_instructionIndex = out_idx_q;
    assign io_out_chosen                = out_chosen_q;

    // Scan from ptr upward; NUM_REQ is a power of two so the index wraps by truncation.
    always_comb begin
        logic [CHOSEN_W-1:0] idx;
        winner    = ptr_q;
        any_valid = 1'b0;
        idx       = ptr_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ptr_q + k[CHOSEN_W-1:0];
            if (!any_valid && io_in_valid[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        load        = !out_valid_q || io_out_ready;
        grant       = load && any_valid && !reset;
        io_in_ready = '0;
        if (grant) begin
            io_in_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_vs_d     = out_vs_q;
        out_src_d    = out_src_q;
        out_off_d    = out_off_q;
        out_idx_d    = out_idx_q;
        out_chosen_d = out_chosen_q;
        ptr_d        = ptr_q;
        if (load) begin
            out_valid_d = grant;
        end
        if (grant) begin
            out_chosen_d = winner;
            ptr_d        = winner + 1'b1;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (winner == i[CHOSEN_W-1:0]) begin
                    out_vs_d  = io_in_bits_vs[i*VS_W +: VS_W];
                    out_src_d = io_in_bits_readSource[i*SRC_W +: SRC_W];
                    out_off_d = io_in_bits_offset[i*OFF_W +: OFF_W];
                    out_idx_d = io_in_bits_instructionIndex[i*IDX_W +: IDX_W];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_vs_q     <= '0;
            out_src_q    <= '0;
            out_off_q    <= '0;
            out_idx_q    <= '0;
            out_chosen_q <= '0;
            ptr_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_vs_q     <= out_vs_d;
            out_src_q    <= out_src_d;
            out_off_q    <= out_off_d;
            out_idx_q    <= out_idx_d;
            out_chosen_q <= out_chosen_d;
            ptr_q        <= ptr_d;
        end
    end

endmodule
